// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings for uart_fifo.
//   Parity selector values, RX/TX state enums, RX FIFO entry layout and a
//   helper that builds the data-bit mask for 5..8 bit frames.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  // One received frame as stored in the RX FIFO.
  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } rx_entry_t;

  function automatic logic [7:0] data_mask(input int unsigned nbits);
    return 8'((16'd1 << nbits) - 16'd1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO, binary pointers with a wrap bit.
//   clk, reset : clock, asynchronous active-high reset (empties the FIFO)
//   push, din  : write request and data; dropped when full unless popping too
//   pop        : read request; ignored when empty
//   dout       : current head entry
//   full/empty : occupancy flags derived from the pointers
module sync_fifo #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointer update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/uart_fifo.sv
// uart_fifo: full-duplex UART with 16x oversampled RX and TX/RX FIFOs.
//   clk, reset          : clock, asynchronous active-high reset
//   uart_rxd / uart_txd : serial in (asynchronous) / serial out (idle high)
//   tx_data, tx_wr      : byte push into TX FIFO; tx_full, tx_busy status
//   rx_data, rx_avail   : show-ahead head of RX FIFO; rx_ack pops it
//   rx_error, rx_perr   : framing / parity error of the head entry
//   rx_overrun          : sticky frame-dropped flag, cleared by rx_ack
module uart_fifo
  import uart_pkg::*;
#(
  parameter int unsigned freq_hz    = 50000000,
  parameter int unsigned baud       = 115200,
  parameter int unsigned data_bits  = 8,
  parameter int unsigned parity     = 0,
  parameter int unsigned stop_bits  = 1,
  parameter int unsigned fifo_depth = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic       uart_txd,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_full,
  output logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  input  logic       rx_ack,
  output logic       rx_error,
  output logic       rx_perr,
  output logic       rx_overrun
);

  localparam int unsigned DIV      = freq_hz / (16 * baud);
  localparam int unsigned TICK_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BIT_CLKS = 16 * DIV;
  localparam int unsigned BIT_W    = $clog2(BIT_CLKS);
  localparam logic [7:0]  DMASK    = data_mask(data_bits);
  localparam logic        PAR_EN   = (parity != PAR_NONE);
  localparam logic        PAR_INV  = (parity == PAR_ODD);
  localparam logic        TWO_STOP = (stop_bits == 2);

  // Oversample tick generator.
  logic [TICK_W-1:0] tick_cnt;
  logic              tick16;

  assign tick16 = (tick_cnt == TICK_W'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       tick_cnt <= '0;
    else if (tick16) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + TICK_W'(1);
  end

  // RX synchroniser plus one delay stage for falling-edge detection.
  logic rx_s1, rx_s2, rx_prev, rx_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall = rx_prev & ~rx_s2;

  // RX FSM: start sampled on the 8th tick, every later bit 16 ticks on.
  rx_state_t  rx_state;
  logic [3:0] rx_sub;
  logic [2:0] rx_bit;
  logic [7:0] rx_shreg;
  logic       rx_parbit;
  logic       rx_sample;
  logic       rx_push;
  logic       rx_pop;
  logic       rx_full;
  logic       rx_empty;
  rx_entry_t  rx_entry;
  rx_entry_t  rx_head;

  assign rx_sample = tick16 && (rx_sub == ((rx_state == RX_START) ? 4'd7 : 4'd15));
  assign rx_push   = (rx_state == RX_STOP) && rx_sample;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state  <= RX_IDLE;
      rx_sub    <= 4'd0;
      rx_bit    <= 3'd0;
      rx_shreg  <= 8'd0;
      rx_parbit <= 1'b0;
    end else begin
      if (rx_state != RX_IDLE && tick16)
        rx_sub <= rx_sample ? 4'd0 : rx_sub + 4'd1;
      unique case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state <= RX_START;
            rx_sub   <= 4'd0;
            rx_bit   <= 3'd0;
            rx_shreg <= 8'd0;
          end
        end
        RX_START: begin
          if (rx_sample) rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
        end
        RX_DATA: begin
          if (rx_sample) begin
            rx_shreg[rx_bit] <= rx_s2;
            if (rx_bit == 3'(data_bits - 1)) rx_state <= PAR_EN ? RX_PARITY : RX_STOP;
            else                             rx_bit   <= rx_bit + 3'd1;
          end
        end
        RX_PARITY: begin
          if (rx_sample) begin
            rx_parbit <= rx_s2;
            rx_state  <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_sample) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign rx_entry.data = rx_shreg;
  assign rx_entry.ferr = ~rx_s2;
  assign rx_entry.perr = PAR_EN && (rx_parbit != ((^rx_shreg) ^ PAR_INV));
  assign rx_pop        = rx_ack && !rx_empty;

  sync_fifo #(.width(10), .depth(fifo_depth)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_ack),
    .din   (rx_entry),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // Overrun only when the full FIFO is not being popped in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              rx_overrun <= 1'b0;
    else if (rx_push && rx_full && !rx_pop) rx_overrun <= 1'b1;
    else if (rx_pop)                        rx_overrun <= 1'b0;
  end

  assign rx_avail = !rx_empty;
  assign rx_data  = rx_avail ? rx_head.data : 8'd0;
  assign rx_error = rx_avail && rx_head.ferr;
  assign rx_perr  = rx_avail && rx_head.perr;

  // TX FIFO and shifter.
  tx_state_t        tx_state;
  logic [BIT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic             tx_stop;
  logic [7:0]       tx_shreg;
  logic             tx_par;
  logic [7:0]       tx_head;
  logic             tx_empty;
  logic             tx_bit_end;
  logic             tx_last_stop;
  logic             tx_pop;

  sync_fifo #(.width(8), .depth(fifo_depth)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_wr && !tx_full),
    .pop   (tx_pop),
    .din   (tx_data & DMASK),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign tx_bit_end   = (tx_cnt == BIT_W'(BIT_CLKS - 1));
  assign tx_last_stop = !TWO_STOP || tx_stop;
  // Load from IDLE, or chain straight into the next frame at the end of STOP.
  assign tx_pop = !tx_empty &&
                  ((tx_state == TX_IDLE) ||
                   (tx_state == TX_STOP && tx_bit_end && tx_last_stop));

  // TX FSM; line and busy are registered from the current state, so both lag it by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= 3'd0;
      tx_stop  <= 1'b0;
      tx_shreg <= 8'd0;
      tx_par   <= 1'b0;
      uart_txd <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      tx_busy <= (tx_state != TX_IDLE) || !tx_empty;
      unique case (tx_state)
        TX_START:  uart_txd <= 1'b0;
        TX_DATA:   uart_txd <= tx_shreg[tx_bit];
        TX_PARITY: uart_txd <= tx_par;
        default:   uart_txd <= 1'b1;
      endcase
      if (tx_state != TX_IDLE)
        tx_cnt <= tx_bit_end ? '0 : tx_cnt + BIT_W'(1);
      if (tx_pop) begin
        tx_shreg <= tx_head;
        tx_par   <= (^tx_head) ^ PAR_INV;
        tx_state <= TX_START;
        tx_cnt   <= '0;
      end else begin
        unique case (tx_state)
          TX_START: begin
            if (tx_bit_end) begin
              tx_state <= TX_DATA;
              tx_bit   <= 3'd0;
              tx_stop  <= 1'b0;
            end
          end
          TX_DATA: begin
            if (tx_bit_end) begin
              if (tx_bit == 3'(data_bits - 1)) tx_state <= PAR_EN ? TX_PARITY : TX_STOP;
              else                             tx_bit   <= tx_bit + 3'd1;
            end
          end
          TX_PARITY: begin
            if (tx_bit_end) tx_state <= TX_STOP;
          end
          TX_STOP: begin
            if (tx_bit_end) begin
              if (tx_last_stop) tx_state <= TX_IDLE;
              else              tx_stop  <= 1'b1;
            end
          end
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed bench for uart_fifo.
//   u_a: fast 8N1 instance (DIV=2, 32-clock bits) with optional loopback.
//   u_b: default clocking with even parity (DIV=27, 432-clock bits).
module tb_uart_fifo;

  localparam int BIT_A   = 32;
  localparam int FRAME_A = 320;
  localparam int BIT_B   = 432;
  localparam int FRAME_B = 4752;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic       rst_a, rst_b;
  logic       lb_a, drv_a, drv_b;
  logic       rxd_a, txd_a, txd_b;
  logic [7:0] tx_data_a, tx_data_b, rx_data_a, rx_data_b;
  logic       tx_wr_a, tx_wr_b, tx_full_a, tx_full_b, tx_busy_a, tx_busy_b;
  logic       rx_avail_a, rx_avail_b, rx_ack_a, rx_ack_b;
  logic       rx_error_a, rx_error_b, rx_perr_a, rx_perr_b, rx_ovr_a, rx_ovr_b;

  assign rxd_a = lb_a ? txd_a : drv_a;

  uart_fifo #(.freq_hz(1600000), .baud(50000)) u_a (
    .clk(clk), .reset(rst_a), .uart_rxd(rxd_a), .uart_txd(txd_a),
    .tx_data(tx_data_a), .tx_wr(tx_wr_a), .tx_full(tx_full_a), .tx_busy(tx_busy_a),
    .rx_data(rx_data_a), .rx_avail(rx_avail_a), .rx_ack(rx_ack_a),
    .rx_error(rx_error_a), .rx_perr(rx_perr_a), .rx_overrun(rx_ovr_a)
  );

  uart_fifo #(.parity(2)) u_b (
    .clk(clk), .reset(rst_b), .uart_rxd(drv_b), .uart_txd(txd_b),
    .tx_data(tx_data_b), .tx_wr(tx_wr_b), .tx_full(tx_full_b), .tx_busy(tx_busy_b),
    .rx_data(rx_data_b), .rx_avail(rx_avail_b), .rx_ack(rx_ack_b),
    .rx_error(rx_error_b), .rx_perr(rx_perr_b), .rx_overrun(rx_ovr_b)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input bit to_b, input logic v);
    if (to_b) drv_b = v;
    else      drv_a = v;
  endtask

  // Serialise one 8-bit frame onto the selected bench-driven RX line.
  task automatic send_frame(input bit to_b, input logic [7:0] d, input bit par_en,
                            input logic par_bit, input logic stop_bit, input int bitclk);
    set_line(to_b, 1'b0);
    cyc(bitclk);
    for (int i = 0; i < 8; i++) begin
      set_line(to_b, d[i]);
      cyc(bitclk);
    end
    if (par_en) begin
      set_line(to_b, par_bit);
      cyc(bitclk);
    end
    set_line(to_b, stop_bit);
    cyc(bitclk);
    set_line(to_b, 1'b1);
  endtask

  task automatic wait_avail(input bit b, input int maxc, input string tag);
    int n = 0;
    while (!(b ? rx_avail_b : rx_avail_a) && n < maxc) begin
      cyc(1);
      n++;
    end
    chk(tag, 32'(b ? rx_avail_b : rx_avail_a), 1);
  endtask

  task automatic ack(input bit b);
    if (b) rx_ack_b = 1'b1;
    else   rx_ack_a = 1'b1;
    cyc(1);
    rx_ack_a = 1'b0;
    rx_ack_b = 1'b0;
  endtask

  logic [7:0] lb5 [5];
  int t;

  initial begin
    lb5 = '{8'h02, 8'h01, 8'h00, 8'hFF, 8'h80};
    rst_a = 1'b1; rst_b = 1'b1; lb_a = 1'b1; drv_a = 1'b1; drv_b = 1'b1;
    tx_data_a = 8'd0; tx_data_b = 8'd0; tx_wr_a = 1'b0; tx_wr_b = 1'b0;
    rx_ack_a = 1'b0; rx_ack_b = 1'b0;
    cyc(3);

    // Reset values.
    chk("rst_txd", 32'(txd_a), 1);
    chk("rst_status", 32'({tx_full_a, tx_busy_a, rx_avail_a}), 0);
    chk("rst_rx_data", 32'(rx_data_a), 0);
    chk("rst_rx_flags", 32'({rx_error_a, rx_perr_a, rx_ovr_a}), 0);
    chk("rst_txd_b", 32'(txd_b), 1);
    rst_a = 1'b0; rst_b = 1'b0;
    cyc(5);

    // 8N1 loopback of five back-to-back frames.
    for (int i = 0; i < 5; i++) begin
      tx_data_a = lb5[i];
      tx_wr_a   = 1'b1;
      cyc(1);
      if (i == 1) begin
        chk("lb_busy_n1", 32'(tx_busy_a), 1);
        chk("lb_txd_n1", 32'(txd_a), 1);
      end
      if (i == 2) chk("lb_txd_n2", 32'(txd_a), 0);
    end
    tx_wr_a = 1'b0;
    t = 4;
    while (tx_busy_a && t < 5000) begin
      cyc(1);
      t++;
    end
    chk("lb_span", 32'(t), 32'(2 + 5 * FRAME_A));
    cyc(5);
    for (int i = 0; i < 5; i++) begin
      chk("lb_avail", 32'(rx_avail_a), 1);
      chk("lb_data", 32'(rx_data_a), 32'(lb5[i]));
      chk("lb_flags", 32'({rx_error_a, rx_perr_a, rx_ovr_a}), 0);
      ack(1'b0);
    end
    chk("lb_empty", 32'(rx_avail_a), 0);

    // 17 back-to-back writes: one goes to the shifter, 16 fill the FIFO.
    for (int i = 0; i < 17; i++) begin
      tx_data_a = 8'(8'h40 + i);
      tx_wr_a   = 1'b1;
      cyc(1);
      if (i == 15) chk("tx_full_16th", 32'(tx_full_a), 0);
      if (i == 16) chk("tx_full_17th", 32'(tx_full_a), 1);
    end
    tx_data_a = 8'hEE;
    cyc(1);
    tx_wr_a = 1'b0;
    chk("tx_full_hold", 32'(tx_full_a), 1);
    for (int k = 0; k < 17; k++) begin
      wait_avail(1'b0, 1000, "tx17_timeout");
      chk("tx17_data", 32'(rx_data_a), 32'(8'h40 + k));
      ack(1'b0);
    end
    cyc(2 * FRAME_A);
    chk("tx17_no_drop_byte", 32'(rx_avail_a), 0);
    chk("tx17_idle", 32'(tx_busy_a), 0);

    // RX overrun: 17 frames arrive with no acknowledge.
    for (int i = 0; i < 17; i++) begin
      tx_data_a = 8'(8'h60 + i);
      tx_wr_a   = 1'b1;
      cyc(1);
    end
    tx_wr_a = 1'b0;
    t = 0;
    while (tx_busy_a && t < 8000) begin
      cyc(1);
      t++;
    end
    chk("ovr_drain", 32'(tx_busy_a), 0);
    cyc(10);
    chk("ovr_set", 32'(rx_ovr_a), 1);
    chk("ovr_head", 32'(rx_data_a), 32'h60);
    ack(1'b0);
    chk("ovr_clear", 32'(rx_ovr_a), 0);
    for (int k = 1; k < 16; k++) begin
      chk("ovr_data", 32'(rx_data_a), 32'(8'h60 + k));
      ack(1'b0);
    end
    chk("ovr_empty", 32'(rx_avail_a), 0);

    // Framing error and a short glitch on the fast instance.
    lb_a = 1'b0;
    cyc(BIT_A);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, BIT_A);
    cyc(5);
    chk("ferr_avail", 32'(rx_avail_a), 1);
    chk("ferr_data", 32'(rx_data_a), 32'h3C);
    chk("ferr_flags", 32'({rx_error_a, rx_perr_a}), 32'b10);
    ack(1'b0);
    drv_a = 1'b0;
    cyc(6);
    drv_a = 1'b1;
    cyc(FRAME_A + 80);
    chk("glitch_a_no_push", 32'(rx_avail_a), 0);

    // Even parity: wrong, then correct parity bit on 0xA5.
    send_frame(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, BIT_B);
    cyc(5);
    chk("perr_avail", 32'(rx_avail_b), 1);
    chk("perr_data", 32'(rx_data_b), 32'hA5);
    chk("perr_flags", 32'({rx_error_b, rx_perr_b}), 32'b01);
    ack(1'b1);
    send_frame(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, BIT_B);
    cyc(5);
    chk("par_ok_data", 32'(rx_data_b), 32'hA5);
    chk("par_ok_flags", 32'({rx_avail_b, rx_error_b, rx_perr_b}), 32'b100);
    ack(1'b1);
    chk("par_empty", 32'(rx_avail_b), 0);

    // 100-clock glitch at default clocking is a false start.
    drv_b = 1'b0;
    cyc(100);
    drv_b = 1'b1;
    cyc(FRAME_B + 200);
    chk("glitch_b_no_push", 32'(rx_avail_b), 0);

    // TX of 0x07 on 8E1: bit values mid-bit and exact frame length.
    tx_data_b = 8'h07;
    tx_wr_b   = 1'b1;
    cyc(1);
    tx_wr_b = 1'b0;
    t = 0;
    while (txd_b && t < 10) begin
      cyc(1);
      t++;
    end
    chk("txb_fall_edge", 32'(t), 2);
    cyc(BIT_B + BIT_B / 2);
    chk("txb_d0", 32'(txd_b), 1);
    cyc(3 * BIT_B);
    chk("txb_d3", 32'(txd_b), 0);
    cyc(5 * BIT_B);
    chk("txb_parity", 32'(txd_b), 1);
    t = 9 * BIT_B + BIT_B / 2;
    while (tx_busy_b && t < 2 * FRAME_B) begin
      cyc(1);
      t++;
    end
    chk("txb_frame_len", 32'(t), 32'(FRAME_B));

    // Reset halfway through TX of 0xC3 and RX of 0x5A.
    tx_data_a = 8'hC3;
    tx_wr_a   = 1'b1;
    cyc(1);
    tx_wr_a = 1'b0;
    drv_a = 1'b0;
    cyc(BIT_A);
    for (int i = 0; i < 4; i++) begin
      drv_a = (i % 2) == 1;
      cyc(BIT_A);
    end
    chk("mid_txd_low", 32'(txd_a), 0);
    chk("mid_busy", 32'(tx_busy_a), 1);
    rst_a = 1'b1;
    drv_a = 1'b1;
    #1;
    chk("rst_mid_txd", 32'(txd_a), 1);
    chk("rst_mid_state", 32'({tx_busy_a, rx_avail_a}), 0);
    cyc(3);
    rst_a = 1'b0;
    cyc(FRAME_A + 80);
    chk("post_rst_idle", 32'({txd_a, tx_busy_a, rx_avail_a}), 32'b100);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, BIT_A);
    cyc(5);
    chk("post_rst_avail", 32'(rx_avail_a), 1);
    chk("post_rst_data", 32'(rx_data_a), 32'h5A);
    chk("post_rst_flags", 32'({rx_error_a, rx_perr_a, rx_ovr_a}), 0);
    ack(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
